// File: rtl/pipe_cla_adder_pkg.sv
// cla_pkg: shared constants and lookahead helpers for pipe_cla_adder.
// Group width 16, max operand width 128, NG-level and 4-bit lookahead functions.
package cla_pkg;

  localparam int CLA_GROUP_W = 16;
  localparam int CLA_MAX_W   = 128;
  localparam int CLA_MAX_NG  = CLA_MAX_W / CLA_GROUP_W;

  // Carry vector c[0..NG] across groups. Unused upper groups are fed
  // with G=P=0, so the extra carries are 0 and get truncated by callers.
  function automatic logic [CLA_MAX_NG:0] cla_lookahead(
    input logic [CLA_MAX_NG-1:0] g,
    input logic [CLA_MAX_NG-1:0] p,
    input logic                  cin
  );
    logic [CLA_MAX_NG:0] c;
    c[0] = cin;
    for (int i = 0; i < CLA_MAX_NG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return c;
  endfunction

  // Carries into positions 0..3 of a 4-wide lookahead block.
  function automatic logic [3:0] la4_carry(
    input logic [3:0] g,
    input logic [3:0] p,
    input logic       c0
  );
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Block {generate, propagate} of a 4-wide lookahead block.
  function automatic logic [1:0] la4_gp(
    input logic [3:0] g,
    input logic [3:0] p
  );
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

endpackage

// File: rtl/pipe_cla_adder_if.sv
// pipe_cla_adder_if: operand/result valid-ready bundle for pipe_cla_adder.
// master = producer/consumer side, slave = adder side; sub under PIPE_CLA_SUB_EN.
interface pipe_cla_adder_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPE_CLA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef PIPE_CLA_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
`ifdef PIPE_CLA_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/pipe_cla_adder_group16.sv
// cla_group16: 16-bit CLA group, four 4-bit blocks plus a 4-bit generator.
// In a_i/b_i; out g_o/p_o, sum0_o/sum1_o (cin 0/1), msbc0_o/msbc1_o (carry into bit 15).
module cla_group16
  import cla_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        g_o,
  output logic        p_o,
  output logic [15:0] sum0_o,
  output logic [15:0] sum1_o,
  output logic        msbc0_o,
  output logic        msbc1_o
);

  logic [15:0] gb;
  logic [15:0] pb;
  logic [15:0] c0;
  logic [15:0] c1;
  logic [3:0]  bg;
  logic [3:0]  bp;
  logic [3:0]  bc0;
  logic [3:0]  bc1;

  always_comb begin
    gb = a_i & b_i;
    pb = a_i ^ b_i;
    bg = '0;
    bp = '0;
    c0 = '0;
    c1 = '0;
    for (int j = 0; j < 4; j++) begin
      {bg[j], bp[j]} = la4_gp(gb[4*j +: 4], pb[4*j +: 4]);
    end
    bc0 = la4_carry(bg, bp, 1'b0);
    bc1 = la4_carry(bg, bp, 1'b1);
    for (int j = 0; j < 4; j++) begin
      c0[4*j +: 4] = la4_carry(gb[4*j +: 4], pb[4*j +: 4], bc0[j]);
      c1[4*j +: 4] = la4_carry(gb[4*j +: 4], pb[4*j +: 4], bc1[j]);
    end
    {g_o, p_o} = la4_gp(bg, bp);
    sum0_o  = pb ^ c0;
    sum1_o  = pb ^ c1;
    msbc0_o = c0[15];
    msbc1_o = c1[15];
  end

endmodule

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: 2-stage pipelined carry-select CLA, 16-bit groups, valid/ready.
// Ports clk, rst (sync, high), bus (pipe_cla_adder_if.slave); PIPE_CLA_SUB_EN adds sub.
module pipe_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  pipe_cla_adder_if.slave bus
);

  localparam int NG = WIDTH / CLA_GROUP_W;

  if ((WIDTH % CLA_GROUP_W) != 0 || WIDTH < CLA_GROUP_W
      || WIDTH > CLA_MAX_W) begin : g_bad_width
    $error("pipe_cla_adder: WIDTH must be a multiple of 16 in 16..128");
  end

  if ($bits(bus.a) != WIDTH) begin : g_bad_bus
    $error("pipe_cla_adder: bus WIDTH differs from adder WIDTH");
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef PIPE_CLA_SUB_EN
  // Subtract as a + ~b + 1; cin is overridden.
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub | bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic [NG-1:0]    mc0;
  logic [NG-1:0]    mc1;

  for (genvar i = 0; i < NG; i++) begin : g_grp
    cla_group16 u_grp (
      .a_i     (bus.a[16*i +: 16]),
      .b_i     (b_eff[16*i +: 16]),
      .g_o     (gg[i]),
      .p_o     (gp[i]),
      .sum0_o  (s0[16*i +: 16]),
      .sum1_o  (s1[16*i +: 16]),
      .msbc0_o (mc0[i]),
      .msbc1_o (mc1[i])
    );
  end

  // Only the top group's MSB carries feed the overflow flag.
  logic unused_msbc;
  assign unused_msbc = ^{mc0, mc1};

  logic             v1_q,    v1_d;
  logic [NG-1:0]    g1_q,    g1_d;
  logic [NG-1:0]    p1_q,    p1_d;
  logic [WIDTH-1:0] s01_q,   s01_d;
  logic [WIDTH-1:0] s11_q,   s11_d;
  logic             mc01_q,  mc01_d;
  logic             mc11_q,  mc11_d;
  logic             cin1_q,  cin1_d;

  logic             v2_q,    v2_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic             s2_adv;
  logic             in_rdy;
  logic             s1_fire;
  logic             s2_load;

  assign s2_adv  = !v2_q || bus.out_ready;
  assign in_rdy  = !v1_q || s2_adv;
  assign s1_fire = bus.in_valid && in_rdy;
  assign s2_load = v1_q && s2_adv;

  logic [NG:0]      c;
  logic [WIDTH-1:0] sel;
  logic             msbc;

  always_comb begin
    c = (NG+1)'(cla_lookahead(CLA_MAX_NG'(g1_q), CLA_MAX_NG'(p1_q), cin1_q));
    sel = s01_q;
    for (int i = 0; i < NG; i++) begin
      if (c[i]) sel[16*i +: 16] = s11_q[16*i +: 16];
    end
    msbc = c[NG-1] ? mc11_q : mc01_q;
  end

  always_comb begin
    v1_d   = v1_q;
    g1_d   = g1_q;
    p1_d   = p1_q;
    s01_d  = s01_q;
    s11_d  = s11_q;
    mc01_d = mc01_q;
    mc11_d = mc11_q;
    cin1_d = cin1_q;
    v2_d   = v2_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (in_rdy) v1_d = bus.in_valid;
    if (s1_fire) begin
      g1_d   = gg;
      p1_d   = gp;
      s01_d  = s0;
      s11_d  = s1;
      mc01_d = mc0[NG-1];
      mc11_d = mc1[NG-1];
      cin1_d = cin_eff;
    end
    if (s2_adv) v2_d = v1_q;
    if (s2_load) begin
      sum_d  = sel;
      cout_d = c[NG];
      ovf_d  = msbc ^ c[NG];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      g1_q   <= '0;
      p1_q   <= '0;
      s01_q  <= '0;
      s11_q  <= '0;
      mc01_q <= 1'b0;
      mc11_q <= 1'b0;
      cin1_q <= 1'b0;
      v2_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      g1_q   <= g1_d;
      p1_q   <= p1_d;
      s01_q  <= s01_d;
      s11_q  <= s11_d;
      mc01_q <= mc01_d;
      mc11_q <= mc11_d;
      cin1_q <= cin1_d;
      v2_q   <= v2_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = v2_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb_pipe_cla_adder: directed vector table plus stall, stream and reset sequences.
// WIDTH=32; sub vectors run when PIPE_CLA_SUB_EN is defined.
module tb_pipe_cla_adder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sb;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_cla_adder_if #(.WIDTH(32)) bus ();

  pipe_cla_adder #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.a   = v.a;
    bus.b   = v.b;
    bus.cin = v.cin;
`ifdef PIPE_CLA_SUB_EN
    bus.sub = v.sb;
`endif
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    drive(v);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("lat_v%0d", idx), 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("valid_v%0d", idx), 64'(bus.out_valid), 64'd1);
    chk($sformatf("sum_v%0d", idx), 64'(bus.sum), 64'(v.s));
    chk($sformatf("cout_v%0d", idx), 64'(bus.cout), 64'(v.co));
    chk($sformatf("ovf_v%0d", idx), 64'(bus.ovf), 64'(v.ov));
  endtask

  vec_t tbl [11];
  vec_t sv  [2];
  vec_t st  [8];

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int sent;
    int recv;
    int occ;
    logic held_v;
    logic [31:0] held;
    logic saw_block;
    logic [32:0] s33;

    tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2]  = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    tbl[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[4]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    tbl[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[7]  = '{32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[8]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1};
    tbl[9]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[10] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 32'h0001_FFFE, 1'b0, 1'b0};
    sv[0]   = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    sv[1]   = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};

    for (int i = 0; i < 8; i++) begin
      st[i].a   = 32'h1111_1111 * i + 32'h0000_FFFF;
      st[i].b   = 32'hF0F0_F0F0 ^ (i * 3);
      st[i].cin = i[0];
      st[i].sb  = 1'b0;
      s33 = {1'b0, st[i].a} + {1'b0, st[i].b} + 33'(st[i].cin);
      st[i].s   = s33[31:0];
      st[i].co  = s33[32];
      st[i].ov  = (st[i].a[31] == st[i].b[31]) && (s33[31] != st[i].a[31]);
    end

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(tbl[3]);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

`ifdef PIPE_CLA_SUB_EN
    for (int i = 0; i < 2; i++) run_vec(sv[i], 100 + i);
`endif

    // Back-to-back stream with out_ready low in cycles 3..5.
    sent = 0;
    recv = 0;
    held_v = 1'b0;
    held = '0;
    saw_block = 1'b0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      bus.in_valid  = (sent < 8);
      if (sent < 8) drive(st[sent]);
      @(negedge clk);
      if (held_v) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_sum", 64'(bus.sum), 64'(held));
      end
      held_v = bus.out_valid && !bus.out_ready;
      held   = bus.sum;
      occ = sent - recv;
      chk($sformatf("in_ready_c%0d", cyc), 64'(bus.in_ready),
          64'(!(occ == 2 && !bus.out_ready)));
      if (!bus.in_ready) saw_block = 1'b1;
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        if (recv < 8) begin
          chk($sformatf("st_sum%0d", recv), 64'(bus.sum), 64'(st[recv].s));
          chk($sformatf("st_cout%0d", recv), 64'(bus.cout), 64'(st[recv].co));
          chk($sformatf("st_ovf%0d", recv), 64'(bus.ovf), 64'(st[recv].ov));
        end
        recv++;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("st_recv", 64'(recv), 64'd8);
    chk("st_sent", 64'(sent), 64'd8);
    chk("st_blocked", 64'(saw_block), 64'd1);
    @(negedge clk);
    chk("st_no_extra", 64'(bus.out_valid), 64'd0);

    // Fill both stages under back-pressure, then reset.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(tbl[4]);
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_sum", 64'(bus.sum), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("no_stale%0d", i), 64'(bus.out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
